// File: rtl/ram_arbiter_pkg.sv
// Shared constants and state encoding for the RAM arbiter slice.
package mem_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  // Burst counter width: large enough for a burst limit of up to 15.
  localparam int CNT_W = 4;

  // Requester port indices.
  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes and RAM-side wires around the arbiter.
// master = environment (requesters + RAM), slave = the arbiter itself.
interface ram_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              clr_req;

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] ram_w_addr;
  logic [DATA_W-1:0] ram_w_data;
  logic [ADDR_W-1:0] ram_data_addr;
  logic              ram_rw_enable;
  logic              ram_rst;
  logic [DATA_W-1:0] ram_r_data;

  modport master (
    output clr_req,
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  ram_w_addr, ram_w_data, ram_data_addr, ram_rw_enable, ram_rst,
    output ram_r_data
  );

  modport slave (
    input  clr_req,
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output ram_w_addr, ram_w_data, ram_data_addr, ram_rw_enable, ram_rst,
    input  ram_r_data
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a bounded burst for the current owner.
module rr_arb2
  import mem_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             req0,
  input  logic             req1,
  input  logic             last,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             gnt0,
  output logic             gnt1
);

  logic keep_owner;
  logic winner;

  // The previous owner keeps the RAM only inside an active burst that has not
  // reached its limit; after an idle cycle the count is 0 and the turn passes.
  assign keep_owner = (burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST));

  // Resolve one winner per cycle; a lone requester always wins.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    winner = P_CPU;
    if (req0 && req1) begin
      winner = keep_owner ? last : ~last;
      gnt0   = (winner == P_CPU);
      gnt1   = (winner == P_LDR);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU (port 0) and the loader
// (port 1): clear sequencing, grant muxing and the read-valid pipeline.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  state_t            state_q;
  logic              clr_pend_q;
  logic              last_q;
  logic [CNT_W-1:0]  burst_q;
  logic [CNT_W-1:0]  burst_d;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;

  logic              arb_gnt0;
  logic              arb_gnt1;
  logic              run;
  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              gnt_port;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last      (last_q),
    .burst_cnt (burst_q),
    .gnt0      (arb_gnt0),
    .gnt1      (arb_gnt1)
  );

  // Grants exist only in normal running; init and clear cycles block both ports.
  assign run      = (state_q == S_RUN);
  assign gnt0     = run & arb_gnt0;
  assign gnt1     = run & arb_gnt1;
  assign any_gnt  = gnt0 | gnt1;
  assign gnt_port = gnt1 ? P_LDR : P_CPU;

  assign sel_addr  = gnt1 ? bus.addr1  : bus.addr0;
  assign sel_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
  assign sel_we    = gnt1 ? bus.we1    : bus.we0;

  // Idle cycles keep the last granted address/data on the RAM pins.
  assign bus.ram_w_addr    = any_gnt ? sel_addr  : addr_hold_q;
  assign bus.ram_data_addr = any_gnt ? sel_addr  : addr_hold_q;
  assign bus.ram_w_data    = any_gnt ? sel_wdata : wdata_hold_q;
  assign bus.ram_rw_enable = any_gnt & sel_we;
  assign bus.ram_rst       = clr_pend_q;

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = bus.ram_r_data;
  assign bus.rdata1  = bus.ram_r_data;

  // Next burst count: extend a same-port run (saturating), restart on a switch,
  // drop to zero on an idle cycle.
  always_comb begin
    burst_d = '0;
    if (any_gnt) begin
      if (gnt_port != last_q)
        burst_d = CNT_W'(1);
      else if (burst_q >= CNT_W'(MAX_BURST))
        burst_d = CNT_W'(MAX_BURST);
      else
        burst_d = burst_q + CNT_W'(1);
    end
  end

  // Clear sequencer; clr_pend_q is the registered RAM clear strobe. In S_INIT
  // it spends one quiet cycle, then one cycle high before running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_INIT;
      clr_pend_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (!clr_pend_q) begin
            clr_pend_q <= 1'b1;
          end else begin
            clr_pend_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.clr_req) begin
            clr_pend_q <= 1'b1;
            state_q    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // A clr_req arriving here is absorbed by the clear in progress.
          clr_pend_q <= 1'b0;
          state_q    <= S_RUN;
        end
        default: begin
          clr_pend_q <= 1'b0;
          state_q    <= S_INIT;
        end
      endcase
    end
  end

  // Round-robin history: last owner and length of its current burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= P_LDR;
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
      if (any_gnt)
        last_q <= gnt_port;
    end
  end

  // Read-valid pipeline matching the RAM's one-cycle registered read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 & ~bus.we0;
      rvalid1_q <= gnt1 & ~bus.we1;
    end
  end

  // Remember the last granted address/data so the RAM pins stay quiet when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else if (any_gnt) begin
      addr_hold_q  <= sel_addr;
      wdata_hold_q <= sel_wdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, read scoreboard, vector table and
// hand-written arbitration/clear/reset sequences.
module tb_ram_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port RAM: registered read, sync clear, powers up with junk.
  logic [7:0] mem [256];
  logic [7:0] ram_q;
  bit         seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hC3 ^ 8'(i);
      ram_q  <= 8'h00;
      seeded <= 1'b1;
    end else if (bus.ram_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      ram_q <= 8'h00;
    end else begin
      if (bus.ram_rw_enable) mem[bus.ram_w_addr] <= bus.ram_w_data;
      ram_q <= mem[bus.ram_data_addr];
    end
  end
  assign bus.ram_r_data = ram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: grant legality every cycle and in-order read responses.
  exp_t       mon_e;
  int         mon_p;
  logic [7:0] mon_d;
  always @(negedge clk) begin
    if (seeded) begin
      chk("one_gnt", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      chk("gnt0_has_req", 32'(bus.gnt0 & ~bus.req0), 32'd0);
      chk("gnt1_has_req", 32'(bus.gnt1 & ~bus.req1), 32'd0);
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        mon_e = sb_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL rvalid_missing: port %0d no response, required at cycle %0d", mon_e.port, mon_e.cyc);
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        mon_p = bus.rvalid1 ? 1 : 0;
        mon_d = bus.rvalid1 ? bus.rdata1 : bus.rdata0;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rvalid_spurious: port %0d data %0h with nothing outstanding (cycle %0d)", mon_p, mon_d, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rvalid_port", 32'(mon_p), 32'(mon_e.port));
          chk("rvalid_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("rdata", 32'(mon_d), 32'(mon_e.data));
          $display("read  port %0d data %0h expected %0h cycle %0d", mon_p, mon_d, mon_e.data, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wd);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
    end
  endtask

  function automatic logic gnt_of(input int port);
    return (port == 0) ? bus.gnt0 : bus.gnt1;
  endfunction

  // One request held until granted; read expectations go to the scoreboard.
  task automatic do_txn(input int port, input logic we, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp);
    bit got = 1'b0;
    drive(port, 1'b1, we, addr, wd);
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (gnt_of(port)) begin
        got = 1'b1;
        chk("bus_we", 32'(bus.ram_rw_enable), 32'(we));
        chk("bus_raddr", 32'(bus.ram_data_addr), 32'(addr));
        chk("bus_waddr", 32'(bus.ram_w_addr), 32'(addr));
        if (we) chk("bus_wdata", 32'(bus.ram_w_data), 32'(wd));
        if (!we) sb_q.push_back('{port: port, data: exp, cyc: cyc + 1});
        $display("grant port %0d we %0d addr %0h wdata %0h cycle %0d", port, we, addr, wd, cyc);
      end
      step();
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL grant_timeout: port %0d addr %0h got no grant, required one", port, addr);
    end
    drive(port, 1'b0, 1'b0, addr, wd);
  endtask

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[11];

  int pat_a[10];
  int pat_b[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_cnt, rst_at, gnt_at, gnt_seen;

    vt[0]  = '{1, 1'b1, 8'h3C, 8'hA5, 8'h00};
    vt[1]  = '{0, 1'b0, 8'h3C, 8'h00, 8'hA5};  // read-after-write, next cycle
    vt[2]  = '{1, 1'b1, 8'h20, 8'h77, 8'h00};
    vt[3]  = '{0, 1'b1, 8'h21, 8'h5A, 8'h00};
    vt[4]  = '{1, 1'b0, 8'h21, 8'h00, 8'h5A};
    vt[5]  = '{1, 1'b0, 8'h20, 8'h00, 8'h77};
    vt[6]  = '{0, 1'b1, 8'hFF, 8'h11, 8'h00};
    vt[7]  = '{1, 1'b0, 8'hFF, 8'h00, 8'h11};
    vt[8]  = '{0, 1'b1, 8'h00, 8'hFE, 8'h00};
    vt[9]  = '{0, 1'b0, 8'h00, 8'h00, 8'hFE};
    vt[10] = '{1, 1'b0, 8'h55, 8'h00, 8'h00};  // never written since clear
    pat_a = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    pat_b = '{1, 1, 1, 1, 0, 1};

    // Reset state, with a read already waiting on port 0.
    rst = 1'b0;
    bus.clr_req = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rst_rw_enable", 32'(bus.ram_rw_enable), 32'd0);
    chk("rst_ram_rst", 32'(bus.ram_rst), 32'd0);
    step();
    rst = 1'b1;

    // Init clear: one quiet cycle, one ram_rst cycle, then the pending read wins.
    rst_cnt = 0; rst_at = -1; gnt_at = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ram_rst) begin rst_cnt++; rst_at = k; end
      if (bus.gnt0 && gnt_at < 0) begin
        gnt_at = k;
        sb_q.push_back('{port: 0, data: 8'h00, cyc: cyc + 1});
      end
      step();
      if (gnt_at >= 0) bus.req0 = 1'b0;
    end
    chk("init_clear_pulses", 32'(rst_cnt), 32'd1);
    chk("init_clear_cycle", 32'(rst_at), 32'd1);
    chk("init_first_gnt", 32'(gnt_at), 32'd2);

    // Table of single-port accesses.
    for (int i = 0; i < 11; i++)
      do_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);
    step();

    // Both ports request continuously; port 0 has the turn.
    drive(0, 1'b1, 1'b1, 8'h80, 8'h01);
    drive(1, 1'b1, 1'b1, 8'h81, 8'h02);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("burst_gnt0", 32'(bus.gnt0), 32'(pat_a[k] == 0));
      chk("burst_gnt1", 32'(bus.gnt1), 32'(pat_a[k] == 1));
      $display("burst cycle %0d gnt0 %0d gnt1 %0d", k, bus.gnt0, bus.gnt1);
      step();
    end
    drive(0, 1'b0, 1'b0, 8'h80, 8'h01);
    drive(1, 1'b0, 1'b0, 8'h81, 8'h02);
    step();

    // Port 1 alone, port 0 joins mid-burst and waits for the burst limit.
    drive(1, 1'b1, 1'b1, 8'h90, 8'h33);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) drive(0, 1'b1, 1'b1, 8'h91, 8'h44);
      @(negedge clk);
      chk("midburst_gnt0", 32'(bus.gnt0), 32'(pat_b[k] == 0));
      chk("midburst_gnt1", 32'(bus.gnt1), 32'(pat_b[k] == 1));
      $display("midburst cycle %0d gnt0 %0d gnt1 %0d", k, bus.gnt0, bus.gnt1);
      step();
      if (k == 4) drive(0, 1'b0, 1'b0, 8'h91, 8'h44);
    end
    drive(1, 1'b0, 1'b0, 8'h90, 8'h33);
    step();

    // Read granted in the clr_req cycle returns pre-clear data during the clear.
    drive(0, 1'b1, 1'b0, 8'h20, 8'h00);
    bus.clr_req = 1'b1;
    @(negedge clk);
    chk("clr_cycle_gnt0", 32'(bus.gnt0), 32'd1);
    chk("clr_cycle_ram_rst", 32'(bus.ram_rst), 32'd0);
    if (bus.gnt0) sb_q.push_back('{port: 0, data: 8'h77, cyc: cyc + 1});
    step();
    drive(0, 1'b0, 1'b0, 8'h20, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h21, 8'h00);    // second clr_req lands inside the clear
    @(negedge clk);
    chk("clear_ram_rst", 32'(bus.ram_rst), 32'd1);
    chk("clear_no_gnt1", 32'(bus.gnt1), 32'd0);
    step();
    bus.clr_req = 1'b0;
    @(negedge clk);
    chk("clear_merged", 32'(bus.ram_rst), 32'd0);
    chk("post_clear_gnt1", 32'(bus.gnt1), 32'd1);
    if (bus.gnt1) sb_q.push_back('{port: 1, data: 8'h00, cyc: cyc + 1});
    step();
    drive(1, 1'b0, 1'b0, 8'h21, 8'h00);
    do_txn(0, 1'b0, 8'h20, 8'h00, 8'h00);

    // Reset right after a granted read: its rvalid must never appear.
    step();
    drive(0, 1'b1, 1'b0, 8'h3C, 8'h00);
    @(negedge clk);
    chk("pre_rst_gnt0", 32'(bus.gnt0), 32'd1);
    step();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h3C, 8'h00);
    @(negedge clk);
    chk("rst_drops_rvalid0", 32'(bus.rvalid0), 32'd0);
    step();
    step();
    rst = 1'b1;
    rst_cnt = 0; gnt_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ram_rst) rst_cnt++;
      if (bus.gnt0 || bus.gnt1) gnt_seen++;
      step();
    end
    chk("rerst_clear_pulses", 32'(rst_cnt), 32'd1);
    chk("rerst_no_gnt", 32'(gnt_seen), 32'd0);

    step();
    step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
